// File: rtl/vec_seq_pkg.sv
// ============================================================================
// Module   : vec_seq_pkg
// Brief    : Shared types and default parameters for the dot-product sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_seq_pkg;

  localparam int unsigned C_VEC_LEN = 32;
  localparam int unsigned C_IDX_W   = 6;
  localparam int unsigned C_MAC_LAT = 2;

  // All-ones index marks "no element selected"
  localparam logic [C_IDX_W-1:0] C_IDLE_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_idx_counter.sv
// ============================================================================
// Module   : seq_idx_counter
// Brief    : Element index register with load-zero, increment and park-at-all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_idx_counter #(
  parameter int unsigned VEC_LEN = 32,
  parameter int unsigned IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_zero,
  input  logic             inc,
  input  logic             to_idle,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic [IDX_W-1:0] r_idx;

  // Parking has priority so an abandoned pass never leaves a live index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '1;
    end else if (to_idle) begin
      r_idx <= '1;
    end else if (load_zero) begin
      r_idx <= '0;
    end else if (inc) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign idx  = r_idx;
  assign last = (r_idx == C_LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/vec_mac_sequencer.sv
// ============================================================================
// Module   : vec_mac_sequencer
// Brief    : Handshaked control FSM for one dot-product pass of the MAC datapath.
//            Optional abort input enabled by defining VEC_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mac_sequencer
  import vec_seq_pkg::*;
#(
  parameter int unsigned VEC_LEN = C_VEC_LEN,
  parameter int unsigned IDX_W   = C_IDX_W,
  parameter int unsigned MAC_LAT = C_MAC_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_ready,
  output logic             busy,
  input  logic             op_valid,
  output logic [IDX_W-1:0] elem_idx,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             res_valid,
  input  logic             res_ready
`ifdef VEC_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int unsigned      DRN_W      = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRN_W-1:0] C_DRN_LOAD = DRN_W'(MAC_LAT - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [DRN_W-1:0] r_drn_cnt;
  logic [DRN_W-1:0] w_drn_nxt;

  logic w_in_pass;
  logic w_kill;
  logic w_idx_load;
  logic w_idx_inc;
  logic w_idx_idle;
  logic w_idx_last;

  assign w_in_pass = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef VEC_SEQ_ABORT_EN
  assign w_kill = abort && w_in_pass;
`else
  assign w_kill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_drn_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_drn_cnt <= w_drn_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drn_nxt   = r_drn_cnt;
    w_idx_load  = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_idle  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_RUN;
        w_idx_load  = 1'b1;
      end
      S_RUN: begin
        if (op_valid) begin
          if (w_idx_last) begin
            w_state_nxt = S_DRAIN;
            w_idx_idle  = 1'b1;
            w_drn_nxt   = C_DRN_LOAD;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last MAC issued needs MAC_LAT cycles before the accumulator is final
        if (r_drn_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drn_nxt = r_drn_cnt - DRN_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_idle  = 1'b1;
      end
    endcase

    if (w_kill) begin
      w_state_nxt = S_IDLE;
      w_idx_load  = 1'b0;
      w_idx_inc   = 1'b0;
      w_idx_idle  = 1'b1;
    end
  end

  seq_idx_counter #(
    .VEC_LEN (VEC_LEN),
    .IDX_W   (IDX_W)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .load_zero (w_idx_load),
    .inc       (w_idx_inc),
    .to_idle   (w_idx_idle),
    .idx       (elem_idx),
    .last      (w_idx_last)
  );

  assign start_ready = (r_state == S_IDLE);
  assign busy        = w_in_pass;
  assign acc_clr     = (r_state == S_CLEAR);
  assign res_valid   = (r_state == S_DONE);
  assign mac_en      = (r_state == S_RUN) && op_valid;

endmodule

`default_nettype wire

// File: tb/tb_vec_mac_sequencer.sv
// ============================================================================
// Module   : tb_vec_mac_sequencer
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a pass-progress reference model (VEC_SEQ_ABORT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mac_sequencer;
  import vec_seq_pkg::*;

  localparam int VL = C_VEC_LEN;
  localparam int IW = C_IDX_W;
  localparam int ML = C_MAC_LAT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start_ready;
  logic          busy;
  logic          op_valid;
  logic [IW-1:0] elem_idx;
  logic          acc_clr;
  logic          mac_en;
  logic          res_valid;
  logic          res_ready;
  logic          abort;

  int checks = 0;
  int errors = 0;

  // Reference model: a pass is described by its age, elements consumed and drain cycles elapsed
  bit m_act;
  int m_age;
  int m_cnt;
  int m_dr;
  bit s_rv;

  always #5 clk = ~clk;

  vec_mac_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .busy        (busy),
    .op_valid    (op_valid),
    .elem_idx    (elem_idx),
    .acc_clr     (acc_clr),
    .mac_en      (mac_en),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
`ifdef VEC_SEQ_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    bit e_sr, e_busy, e_clr, e_mac, e_rv;
    int e_idx;
    @(negedge clk);
    e_sr = 0; e_busy = 0; e_clr = 0; e_mac = 0; e_rv = 0; e_idx = (1 << IW) - 1;
    if (!m_act) begin
      e_sr = 1;
    end else if (m_age == 1) begin
      e_clr = 1; e_busy = 1;
    end else if (m_cnt < VL) begin
      e_busy = 1; e_idx = m_cnt; e_mac = op_valid;
    end else if (m_dr < ML) begin
      e_busy = 1;
    end else begin
      e_rv = 1;
    end
    check("start_ready", 32'(start_ready), 32'(e_sr));
    check("busy",        32'(busy),        32'(e_busy));
    check("acc_clr",     32'(acc_clr),     32'(e_clr));
    check("mac_en",      32'(mac_en),      32'(e_mac));
    check("res_valid",   32'(res_valid),   32'(e_rv));
    check("elem_idx",    32'(elem_idx),    32'(e_idx));
    s_rv = res_valid;
    @(posedge clk);
    if (rst) begin
      m_act = 0;
    end else if (abort && m_act && !(m_cnt == VL && m_dr == ML)) begin
      m_act = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_age = 1; m_cnt = 0; m_dr = 0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_cnt < VL) begin
      if (op_valid) m_cnt++;
    end else if (m_dr < ML) begin
      m_dr++;
    end else if (res_ready) begin
      m_act = 0;
    end
    #1;
  endtask

  // Starts a pass at the next edge and returns cycles until res_valid (0 if never seen)
  task automatic run_pass(input int stall_from, input int stall_len, output int lat);
    lat = 0;
    start = 1;
    step();
    start = 0;
    for (int i = 1; i < 200 && lat == 0; i++) begin
      op_valid = !(i >= stall_from && i < stall_from + stall_len);
      step();
      if (s_rv) lat = i;
    end
    op_valid = 1;
  endtask

  initial begin
    int lat;
    int clr_cnt;
    int rv_seen;
    m_act = 0; m_age = 0; m_cnt = 0; m_dr = 0;
    rst = 1; start = 0; op_valid = 1; res_ready = 1; abort = 0;
    #1;
    step();
    step();
    rst = 0;
    step();

    // Nominal pass
    run_pass(0, 0, lat);
    check("latency_nominal", 32'(lat), 32'(VL + 2 + ML));
    step();

    // Three-cycle operand gap at index 10 (cycle 12)
    run_pass(12, 3, lat);
    check("latency_stall", 32'(lat), 32'(VL + 2 + ML + 3));
    step();

    // Consumer back-pressure with start pulses in DONE
    res_ready = 0;
    run_pass(0, 0, lat);
    start = 1;
    for (int i = 0; i < 5; i++) step();
    start = 0;
    res_ready = 1;
    step();
    step();
    check("idle_after_release", 32'(start_ready), 32'd1);

    // Reset while index is 20
    start = 1;
    step();
    start = 0;
    for (int i = 1; i < 22; i++) step();
    rst = 1;
    step();
    rst = 0;
    check("idx_after_rst", 32'(elem_idx), 32'h3F);
    rv_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      rv_seen += int'(s_rv);
    end
    check("no_rv_after_rst", 32'(rv_seen), 32'd0);

    // Start held continuously: passes back-to-back with one acc_clr each
    start = 1;
    clr_cnt = 0;
    rv_seen = 0;
    for (int i = 0; i < 3 * (VL + 3 + ML); i++) begin
      step();
      clr_cnt += int'(acc_clr);
      rv_seen += int'(s_rv);
    end
    start = 0;
    check("b2b_clr_count", 32'(clr_cnt), 32'd3);
    check("b2b_rv_count",  32'(rv_seen), 32'd3);
    for (int i = 0; i < VL + 8; i++) step();

`ifdef VEC_SEQ_ABORT_EN
    // Abort in the first drain cycle, then a clean pass
    start = 1;
    step();
    start = 0;
    for (int i = 1; i < VL + 2; i++) step();
    abort = 1;
    step();
    abort = 0;
    check("abort_to_idle", 32'(start_ready), 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      rv_seen += int'(s_rv);
    end
    check("abort_no_rv", 32'(rv_seen), 32'd0);
    run_pass(0, 0, lat);
    check("latency_after_abort", 32'(lat), 32'(VL + 2 + ML));
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom % 4) == 0;
      op_valid  = ($urandom % 4) != 0;
      res_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 400) == 0;
`ifdef VEC_SEQ_ABORT_EN
      abort     = ($urandom % 150) == 0;
`endif
      step();
    end
    rst = 0; start = 0; abort = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vec_mac_sequencer.md
# vec_mac_sequencer

Control FSM that sequences one dot-product pass of the 32x32 vector multiplier datapath. It accepts a start request, clears the accumulator, and steps an element index across the operand vectors, advancing only on valid operands. It then waits out the multiply-accumulate pipeline latency and presents a held result-valid until the consumer accepts it. It sits between the operand buffers and the MAC datapath and replaces free-running index counting with a handshaked controller.

## Interface
- VEC_LEN, 32: elements per pass; must be at least 2.
- IDX_W, 6: index width; must satisfy 2^IDX_W > VEC_LEN so the all-ones idle code is never a valid index.
- MAC_LAT, 2: MAC pipeline depth in cycles from `mac_en` to the accumulator being updated; must be at least 1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a pass; accepted only while `start_ready`=1.
- start_ready  out  1  high only in IDLE.
- busy  out  1  high in CLEAR, RUN and DRAIN.
- op_valid  in  1  operand pair at `elem_idx` is present this cycle.
- elem_idx  out  IDX_W  current element index; all-ones whenever the state is not RUN.
- acc_clr  out  1  one-cycle accumulator clear.
- mac_en  out  1  multiply-accumulate enable; equals `op_valid` while in RUN, 0 otherwise.
- res_valid  out  1  accumulator result is final.
- res_ready  in  1  consumer accepts the result.
- abort  in  1  only present when the abort feature is compiled in (see Configuration).

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: `start_ready`=1. When `start`=1, go to CLEAR.
- CLEAR: `acc_clr`=1 for exactly one cycle, then go to RUN. The index loads 0 on entry to RUN.
- RUN: `mac_en`=`op_valid`.
  - `op_valid`=1: the index increments.
  - `op_valid`=1 and `elem_idx`=VEC_LEN-1: go to DRAIN; the index returns to all-ones.
  - `op_valid`=0: the index holds and there is no timeout.
- DRAIN: the drain counter loads MAC_LAT-1 on entry and decrements each cycle. When it reaches 0, go to DONE. No `mac_en` pulses occur in DRAIN.
- DONE: `res_valid`=1, held steady until `res_ready`=1, then go to IDLE. `res_ready` while `res_valid`=0 is ignored.
- `start` outside IDLE is ignored and not queued. `start` in the same cycle that DONE exits is ignored, because `start_ready` is still 0 in that cycle.
- Reset values, which also apply after a reset mid-pass on the following edge:
  - State IDLE, `elem_idx` all-ones.
  - `start_ready`=1.
  - `busy`=0, `acc_clr`=0, `mac_en`=0, `res_valid`=0.
  - No partial result is presented after a reset.
- Index arithmetic is IDX_W-bit unsigned. Wrap from all-ones to 0 happens only on RUN entry; the index never counts past VEC_LEN-1.

## Timing
- Start-to-result latency, with `start` sampled high at edge 0 and `op_valid` held high:
  - CLEAR in cycle 1.
  - RUN in cycles 2 through VEC_LEN+1.
  - DRAIN in the next MAC_LAT cycles.
  - `res_valid` first high in cycle VEC_LEN+2+MAC_LAT. With the defaults this is cycle 36.
- Each cycle with `op_valid` low in RUN adds one cycle to the latency.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to `start_ready`, `busy`, `acc_clr` or `res_valid`.
- `mac_en` is the exception: it is combinational from `op_valid`, gated by the RUN state.
- Back-to-back throughput is one pass per VEC_LEN+3+MAC_LAT cycles when `res_ready` is held high, because the sequencer spends one IDLE cycle between passes.

## Configuration
- Macro: VEC_SEQ_ABORT_EN.
- Defined:
  - The `abort` input exists.
  - `abort`=1 in CLEAR, RUN or DRAIN forces IDLE on the next edge; `elem_idx` goes to all-ones and `mac_en` goes low; `res_valid` is never asserted for that pass.
  - `abort` in IDLE or DONE is ignored.
  - `rst` has priority over `abort`.
- Not defined: the `abort` port is absent and a pass ends only through DONE or `rst`.

## Structure
- Shared package `vec_seq_pkg` holds:
  - the state enum (IDLE, CLEAR, RUN, DRAIN, DONE);
  - the idle-index constant (all-ones of IDX_W);
  - the default VEC_LEN, IDX_W and MAC_LAT values.
- One sub-module, `seq_idx_counter`, holds the element index with:
  - synchronous active-high reset;
  - load-zero, increment-on-enable and return-to-all-ones controls;
  - an output flag for the last index.
- The FSM and the drain counter stay in the top module.

## Test plan
- Reset, then start with `op_valid` held high and `res_ready` held high, defaults: exactly one `acc_clr` in cycle 1; 32 `mac_en` pulses with `elem_idx` 0..31; `res_valid` in cycle 36; back in IDLE in cycle 37.
- `op_valid` low for 3 cycles at index 10: `elem_idx` holds at 10; `mac_en`=0 in those cycles; `res_valid` in cycle 39.
- `res_ready` held low for 5 cycles in DONE: `res_valid` stays high and stable, `start` pulses are ignored; release `res_ready`, then IDLE on the next cycle.
- Assert `rst` for one cycle at index 20: on the next edge all outputs take reset values and `elem_idx`=6'h3F; no `res_valid` follows.
- `start` held high continuously: passes run back-to-back with one IDLE cycle between, and each pass has exactly one `acc_clr`.
- With VEC_SEQ_ABORT_EN defined, `abort` in DRAIN: IDLE on the next edge, `res_valid` never asserted; a following `start` completes normally.
